pe_col_acc: RTL and testbench
=============================

// Module: pe_col_acc
// PURPOSE
//  Downstream stage of a systolic PE column. Consumes the signed partial sum
//  y_out from the column's last PE, one beat per handshake.
//  Accumulates len beats per result into a wide accumulator.
//  Presents each result on a valid/ready output port.
// PARAMETERS
//  WIDTH      8   bit width of incoming partial sum (matches PE WIDTH)
//  ACC_WIDTH  20  accumulator/result width, signed; must be >= WIDTH
//  LEN_WIDTH  8   width of the len (beats-per-result) input
// PORTS
//  clk     in   1          clock, all logic on rising edge
//  rst_n   in   1          asynchronous active-low reset
//  clear   in   1          synchronous abort: drop partial result, go IDLE
//  len     in   LEN_WIDTH  beats per result; sampled on the first beat; 0 treated as 1
//  y_in    in   WIDTH      signed partial sum from PE column
//  y_valid in   1          y_in valid
//  y_ready out  1          stage accepts y_in this cycle
//  m_data  out  ACC_WIDTH  signed accumulated result
//  m_valid out  1          m_data valid
//  m_ready in   1          downstream accepts m_data
//  m_ovf   out  1          result saturated (see CONFIGURATION)
//  busy    out  1          state != IDLE
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; acc=0; cnt=0; len_q=0; m_valid=0; m_ovf=0.
//    Outputs under reset: m_data=0, busy=0, y_ready=0.
//  - Beat accepted when y_valid && y_ready. Output transfer when m_valid && m_ready.
//  - y_ready = !clear && (state!=OUT || m_ready).
//  - m_valid = (state==OUT). m_data = acc register (stable while m_valid && !m_ready).
//  - y_in is sign-extended to ACC_WIDTH before any add.
//  - FSM:
//    - IDLE: on beat: acc=sext(y_in), cnt=1, len_q=max(len,1).
//      Then go OUT if len_q==1, else go ACC.
//    - ACC: on beat: acc=acc+sext(y_in), cnt=cnt+1.
//      Go OUT when the accepted beat makes cnt==len_q. No beat: hold.
//    - OUT: hold acc/m_ovf until m_ready.
//      m_ready && no beat: go IDLE.
//      m_ready && beat (simultaneous): current result completes.
//      The same cycle starts a new result exactly as the IDLE rule, sampling len anew.
//      Back-to-back results therefore need no bubble.
//  - m_ovf: cleared when a new result starts; set when any add of that result overflows.
//  - len changes while state!=IDLE are ignored (only len_q is used).
//  - clear: highest priority below reset.
//    Next edge: state=IDLE, acc=0, cnt=0, m_ovf=0.
//    Any pending m_data is discarded. No beat is accepted in the clear cycle.
//  - Latency: result valid the cycle after its last beat is accepted.
//  - Counter: cnt is LEN_WIDTH bits. Max len = 2^LEN_WIDTH-1. No wrap reachable.
// CONFIGURATION
//  PE_COL_ACC_SAT_EN defined:
//    - Each add saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
//    - On saturation, m_ovf is set (sticky per result).
//  PE_COL_ACC_SAT_EN undefined:
//    - Adds wrap modulo 2^ACC_WIDTH (two's complement).
//    - m_ovf is tied to 0.
// TESTING
//  1 Single beat: len=0, y_in=-5, m_ready=1.
//    -> one cycle later m_valid=1, m_data=-5, then IDLE.
//  2 len=4, beats 10,-3,7,100, m_ready=1.
//    -> m_data=114 the cycle after the 4th beat; busy high 4 cycles.
//  3 Backpressure: len=2, beats 1,2, m_ready=0 for 5 cycles.
//    -> m_data=3 held stable, y_ready=0 throughout, transfer on m_ready=1.
//  4 Back-to-back: len=1, y_valid=1 every cycle with 1,2,3, m_ready=1.
//    -> results 1,2,3 on consecutive cycles, y_ready constantly 1.
//  5 Overflow: ACC_WIDTH=9, len=3, beats 127,127,127.
//    -> SAT_EN: m_data=255, m_ovf=1. Without SAT_EN: m_data=-131, m_ovf=0.
//  6 Abort: len=4, 2 beats then clear=1; also rst_n=0 asserted mid-OUT.
//    -> IDLE next edge (async on reset), m_valid=0, the next len=1 beat 9 gives m_data=9.

Source files
------------

// File: rtl/pe_col_acc.sv
// Column accumulator: sums len signed beats from the last PE into one wide result on a valid/ready port.
// Build option PE_COL_ACC_SAT_EN: saturating adds with sticky m_ovf; otherwise wrapping adds and m_ovf=0.
module pe_col_acc #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [WIDTH-1:0]     y_in,
  input  logic                 y_valid,
  output logic                 y_ready,
  output logic [ACC_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_ovf,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

  state_t               r_state, w_state_nxt;
  logic [ACC_WIDTH-1:0] r_acc, w_acc_nxt;
  logic [LEN_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [LEN_WIDTH-1:0] r_len_q, w_len_q_nxt;
  logic                 r_ovf, w_ovf_nxt;

  logic                 w_beat;
  logic                 w_start;
  logic [ACC_WIDTH-1:0] w_y_sext;
  logic [ACC_WIDTH-1:0] w_add_res;
  logic                 w_add_ovf;
  logic [LEN_WIDTH-1:0] w_len_eff;
  logic [LEN_WIDTH-1:0] w_cnt_inc;

  assign w_y_sext  = ACC_WIDTH'($signed(y_in));
  assign w_len_eff = (len == '0) ? LEN_WIDTH'(1) : len;
  assign w_cnt_inc = r_cnt + LEN_WIDTH'(1);

`ifdef PE_COL_ACC_SAT_EN
  logic [ACC_WIDTH:0] w_sum_ext;
  // One guard bit: overflow when the guard and the result sign disagree.
  assign w_sum_ext = {r_acc[ACC_WIDTH-1], r_acc} + {w_y_sext[ACC_WIDTH-1], w_y_sext};
  assign w_add_ovf = w_sum_ext[ACC_WIDTH] ^ w_sum_ext[ACC_WIDTH-1];
  assign w_add_res = !w_add_ovf         ? w_sum_ext[ACC_WIDTH-1:0] :
                     w_sum_ext[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                            {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
  assign w_add_res = r_acc + w_y_sext;
  assign w_add_ovf = 1'b0;
`endif

  // rst_n gates y_ready so nothing looks acceptable while held in reset.
  assign y_ready = rst_n && !clear && ((r_state != S_OUT) || m_ready);
  assign w_beat  = y_valid && y_ready;
  assign w_start = w_beat && (r_state != S_ACC);
  assign m_valid = (r_state == S_OUT);
  assign m_data  = r_acc;
  assign m_ovf   = r_ovf;
  assign busy    = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_len_q_nxt = r_len_q;
    w_ovf_nxt   = r_ovf;
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_ovf_nxt   = 1'b0;
    end else if (w_start) begin
      // Covers IDLE and the back-to-back case in OUT (beat implies m_ready there).
      w_acc_nxt   = w_y_sext;
      w_cnt_nxt   = LEN_WIDTH'(1);
      w_len_q_nxt = w_len_eff;
      w_ovf_nxt   = 1'b0;
      w_state_nxt = (w_len_eff == LEN_WIDTH'(1)) ? S_OUT : S_ACC;
    end else begin
      case (r_state)
        S_ACC: begin
          if (w_beat) begin
            w_acc_nxt = w_add_res;
            w_cnt_nxt = w_cnt_inc;
            w_ovf_nxt = r_ovf | w_add_ovf;
            if (w_cnt_inc == r_len_q) w_state_nxt = S_OUT;
          end
        end
        S_OUT: begin
          if (m_ready) w_state_nxt = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_len_q <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len_q <= w_len_q_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_pe_col_acc.sv
// Bench for pe_col_acc at ACC_WIDTH=9: directed scenarios plus randomized traffic against a result-level model.
module tb_pe_col_acc;
  localparam int W  = 8;
  localparam int AW = 9;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic [LW-1:0] len = '0;
  logic [W-1:0]  y_in = '0;
  logic          y_valid = 1'b0;
  logic          y_ready;
  logic [AW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_ovf;
  logic          busy;

  int checks = 0;
  int errors = 0;

  pe_col_acc #(.WIDTH(W), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .len(len), .y_in(y_in),
    .y_valid(y_valid), .y_ready(y_ready), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_ovf(m_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic yv, input int y, input int ln, input logic mr, input logic clr);
    y_valid = yv; y_in = W'(y); len = LW'(ln); m_ready = mr; clear = clr;
    #1;
  endtask

  // Result of one accumulation, built from the beat list by plain integer arithmetic.
  function automatic logic [AW-1:0] ref_result(input int b[$], output bit ovf);
    longint acc;
    acc = b[0];
    ovf = 1'b0;
    for (int i = 1; i < b.size(); i++) begin
      acc += b[i];
`ifdef PE_COL_ACC_SAT_EN
      if (acc > (2**(AW-1)) - 1) begin acc = (2**(AW-1)) - 1; ovf = 1'b1; end
      else if (acc < -(2**(AW-1))) begin acc = -(2**(AW-1)); ovf = 1'b1; end
`endif
    end
    return AW'(acc);
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1, 3, 1, 1, 0);
    checks++; if (y_ready !== 1'b0) begin errors++; $display("FAIL reset_y_ready got %b exp 0", y_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data got %0h exp 0", m_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (m_ovf !== 1'b0) begin errors++; $display("FAIL reset_m_ovf got %b exp 0", m_ovf); end
    next_cycle;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_hold_busy got %b exp 0", busy); end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    next_cycle;
  endtask

  task automatic test_single;
    drive(1, -5, 0, 1, 0);
    checks++; if (y_ready !== 1'b1) begin errors++; $display("FAIL single_y_ready got %b exp 1", y_ready); end
    next_cycle;
    drive(0, 0, 0, 1, 0);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_m_valid got %b exp 1", m_valid); end
    checks++; if (m_data !== AW'(-5)) begin errors++; $display("FAIL single_m_data got %0h exp %0h", m_data, AW'(-5)); end
    checks++; if (m_ovf !== 1'b0) begin errors++; $display("FAIL single_m_ovf got %b exp 0", m_ovf); end
    next_cycle;
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got v=%b b=%b exp 0 0", m_valid, busy); end
  endtask

  task automatic test_len4;
    int b[4] = '{10, -3, 7, 100};
    int busy_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, b[i], (i == 0) ? 4 : 1, 1, 0);
      checks++; if (y_ready !== 1'b1) begin errors++; $display("FAIL len4_y_ready beat %0d got %b exp 1", i, y_ready); end
      if (busy) busy_cycles++;
      next_cycle;
    end
    drive(0, 0, 0, 1, 0);
    if (busy) busy_cycles++;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL len4_m_valid got %b exp 1", m_valid); end
    checks++; if (m_data !== AW'(114)) begin errors++; $display("FAIL len4_m_data got %0d exp 114", m_data); end
    next_cycle;
    if (busy) busy_cycles++;
    checks++; if (busy_cycles != 4) begin errors++; $display("FAIL len4_busy_cycles got %0d exp 4", busy_cycles); end
  endtask

  task automatic test_backpressure;
    drive(1, 1, 2, 0, 0); next_cycle;
    drive(1, 2, 0, 0, 0); next_cycle;
    for (int i = 0; i < 5; i++) begin
      drive(1, 50, 1, 0, 0);
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_m_valid cyc %0d got %b exp 1", i, m_valid); end
      checks++; if (m_data !== AW'(3)) begin errors++; $display("FAIL bp_m_data cyc %0d got %0d exp 3", i, m_data); end
      checks++; if (y_ready !== 1'b0) begin errors++; $display("FAIL bp_y_ready cyc %0d got %b exp 0", i, y_ready); end
      next_cycle;
    end
    drive(0, 0, 0, 1, 0);
    checks++; if (m_valid !== 1'b1 || m_data !== AW'(3)) begin errors++; $display("FAIL bp_release got v=%b d=%0d exp 1 3", m_valid, m_data); end
    next_cycle;
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_idle got v=%b b=%b exp 0 0", m_valid, busy); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      drive(i < 3, i + 1, 1, 1, 0);
      checks++; if (y_ready !== 1'b1) begin errors++; $display("FAIL b2b_y_ready cyc %0d got %b exp 1", i, y_ready); end
      if (i > 0) begin
        checks++; if (m_valid !== 1'b1 || m_data !== AW'(i)) begin errors++; $display("FAIL b2b_result cyc %0d got v=%b d=%0d exp 1 %0d", i, m_valid, m_data, i); end
      end
      next_cycle;
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", m_valid); end
  endtask

  task automatic test_overflow;
    logic [AW-1:0] e_data;
    logic          e_ovf;
`ifdef PE_COL_ACC_SAT_EN
    e_data = AW'(255); e_ovf = 1'b1;
`else
    e_data = AW'(-131); e_ovf = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      drive(1, 127, 3, 1, 0); next_cycle;
    end
    drive(1, 1, 1, 1, 0);
    checks++; if (m_data !== e_data) begin errors++; $display("FAIL ovf_m_data got %0h exp %0h", m_data, e_data); end
    checks++; if (m_ovf !== e_ovf) begin errors++; $display("FAIL ovf_flag got %b exp %b", m_ovf, e_ovf); end
    next_cycle;
    drive(0, 0, 0, 1, 0);
    checks++; if (m_data !== AW'(1) || m_ovf !== 1'b0) begin errors++; $display("FAIL ovf_next_result got d=%0d o=%b exp 1 0", m_data, m_ovf); end
    next_cycle;
  endtask

  task automatic test_abort;
    drive(1, 10, 4, 1, 0); next_cycle;
    drive(1, 20, 0, 1, 0); next_cycle;
    drive(1, 30, 1, 1, 1);
    checks++; if (y_ready !== 1'b0) begin errors++; $display("FAIL abort_y_ready got %b exp 0", y_ready); end
    next_cycle;
    drive(0, 0, 0, 1, 0);
    checks++; if (busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL abort_idle got b=%b v=%b exp 0 0", busy, m_valid); end
    drive(1, 9, 1, 1, 0); next_cycle;
    drive(0, 0, 0, 0, 0);
    checks++; if (m_valid !== 1'b1 || m_data !== AW'(9)) begin errors++; $display("FAIL abort_after_clear got v=%b d=%0d exp 1 9", m_valid, m_data); end
    rst_n = 1'b0; #1;
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || m_data !== '0) begin errors++; $display("FAIL abort_async_rst got v=%b b=%b d=%0d exp 0 0 0", m_valid, busy, m_data); end
    next_cycle;
    rst_n = 1'b1;
    drive(1, 9, 1, 1, 0); next_cycle;
    drive(0, 0, 0, 1, 0);
    checks++; if (m_valid !== 1'b1 || m_data !== AW'(9)) begin errors++; $display("FAIL abort_after_rst got v=%b d=%0d exp 1 9", m_valid, m_data); end
    next_cycle;
  endtask

  task automatic test_random;
    int            cur[$];
    logic [AW-1:0] expq[$];
    bit            ovfq[$];
    int            target = 0;
    bit            yv, mr, clr, pend, eyr, o;
    int            y, ln;
    for (int n = 0; n < 800; n++) begin
      yv  = ($urandom_range(0, 9) < 7);
      y   = int'($urandom_range(0, 255)) - 128;
      ln  = $urandom_range(0, 5);
      clr = ($urandom_range(0, 39) == 0);
      mr  = clr ? 1'b0 : ($urandom_range(0, 2) != 0);
      drive(yv, y, ln, mr, clr);
      pend = (expq.size() > 0);
      eyr  = !clr && !(pend && !mr);
      checks++; if (y_ready !== eyr) begin errors++; $display("FAIL rnd_y_ready cyc %0d got %b exp %b", n, y_ready, eyr); end
      checks++; if (m_valid !== pend) begin errors++; $display("FAIL rnd_m_valid cyc %0d got %b exp %b", n, m_valid, pend); end
      checks++; if (busy !== (pend || cur.size() > 0)) begin errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", n, busy, pend || cur.size() > 0); end
      if (pend) begin
        checks++; if (m_data !== expq[0] || m_ovf !== ovfq[0]) begin errors++; $display("FAIL rnd_result cyc %0d got d=%0h o=%b exp d=%0h o=%b", n, m_data, m_ovf, expq[0], ovfq[0]); end
      end
      if (clr) begin
        cur.delete(); expq.delete(); ovfq.delete();
      end else begin
        if (pend && mr) begin void'(expq.pop_front()); void'(ovfq.pop_front()); end
        if (yv && eyr) begin
          if (cur.size() == 0) target = (ln == 0) ? 1 : ln;
          cur.push_back(y);
          if (cur.size() == target) begin
            expq.push_back(ref_result(cur, o));
            ovfq.push_back(o);
            cur.delete();
          end
        end
      end
      next_cycle;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_len4();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
